// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and register-number width for the stall controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERROR = 2'd2} state_e;
  localparam int REG_W = 5;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination feeds the instruction in ID
//   in : IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt
//   out: LoadUse
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  output logic             LoadUse
);
  // r0 is hardwired to zero, so a load into it never creates a dependency
  assign LoadUse = IDEX_MemRead && IDEX_Rt != '0 &&
                   (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard/stall sequencer for the 5-stage pipeline
//   in : Clk, Reset (async, active-low), load-use operands, BranchTaken, MemReq, MemReady
//   out: PCWrite, per-register stall/flush/bubble controls, MemError, State,
//        saturating StallCount / FlushCount
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFID_Stall,
  output logic             IDEX_Stall,
  output logic             EXMEM_Stall,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MEMWB_Bubble,
  output logic             MemError,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             load_use, mem_busy, freeze, flush, stall_lu, pc_write;

  load_use_detect u_lud (
    .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rt     (IDEX_Rt),
    .IFID_Rs     (IFID_Rs),
    .IFID_Rt     (IFID_Rt),
    .IFID_UsesRt (IFID_UsesRt),
    .LoadUse     (load_use)
  );

  // A dropped MemReq in MEM_WAIT is not busy, so it completes the wait like MemReady.
  // Branch outranks load-use: the flushed ID instruction makes the stall moot.
  always_comb begin
    mem_busy    = MemReq && !MemReady;
    freeze      = state_q == ERROR || mem_busy;
    flush       = !freeze && BranchTaken;
    stall_lu    = !freeze && !BranchTaken && load_use;
    pc_write    = !(freeze || stall_lu);
    state_d     = state_q == ERROR ? ERROR :
                  !mem_busy ? RUN :
                  (state_q == MEM_WAIT && wait_cnt_q == WC_W'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
    wait_cnt_d  = state_d != MEM_WAIT ? '0 :
                  state_q == RUN ? WC_W'(1) : wait_cnt_q + 1'b1;
    stall_cnt_d = stall_cnt_q + CNT_W'(!pc_write && stall_cnt_q != '1);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush && flush_cnt_q != '1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Every control output is held low while reset is asserted, PCWrite included
  assign PCWrite      = Reset && pc_write;
  assign IFID_Stall   = Reset && (freeze || stall_lu);
  assign IDEX_Stall   = Reset && freeze;
  assign EXMEM_Stall  = Reset && freeze;
  assign IFID_Flush   = Reset && flush;
  assign IDEX_Bubble  = Reset && (flush || stall_lu);
  assign MEMWB_Bubble = Reset && freeze;
  assign MemError     = Reset && state_q == ERROR;
  assign State        = state_q;
  assign StallCount   = stall_cnt_q;
  assign FlushCount   = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed table plus multi-cycle sequences for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
  localparam int CW = 4;
  localparam logic [7:0] NORM = 8'b1000_0000;
  localparam logic [7:0] LU   = 8'b0100_0100;
  localparam logic [7:0] BR   = 8'b1000_1100;
  localparam logic [7:0] FRZ  = 8'b0111_0010;
  localparam logic [7:0] ERRF = 8'b0111_0011;

  logic Clk = 0, Reset = 0;
  logic IDEX_MemRead = 0, IFID_UsesRt = 0, BranchTaken = 0, MemReq = 0, MemReady = 0;
  logic [4:0] IDEX_Rt = 0, IFID_Rs = 0, IFID_Rt = 0;
  logic PCWrite, IFID_Stall, IDEX_Stall, EXMEM_Stall, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, MemError;
  logic [1:0] State;
  logic [CW-1:0] StallCount, FlushCount;
  int total = 0, bad = 0;

  typedef struct {
    logic mr; logic [4:0] rt; logic [4:0] rs; logic [4:0] rt2;
    logic uses; logic br; logic req; logic rdy; logic [7:0] exp;
  } vec_t;
  vec_t vecs[12];

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .BranchTaken(BranchTaken), .MemReq(MemReq), .MemReady(MemReady),
    .PCWrite(PCWrite), .IFID_Stall(IFID_Stall), .IDEX_Stall(IDEX_Stall),
    .EXMEM_Stall(EXMEM_Stall), .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
    .MEMWB_Bubble(MEMWB_Bubble), .MemError(MemError), .State(State),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] outs();
    return {PCWrite, IFID_Stall, IDEX_Stall, EXMEM_Stall, IFID_Flush, IDEX_Bubble, MEMWB_Bubble, MemError};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    IDEX_MemRead = v.mr; IDEX_Rt = v.rt; IFID_Rs = v.rs; IFID_Rt = v.rt2;
    IFID_UsesRt = v.uses; BranchTaken = v.br; MemReq = v.req; MemReady = v.rdy;
  endtask

  task automatic clr();
    IDEX_MemRead = 0; IDEX_Rt = 0; IFID_Rs = 0; IFID_Rt = 0;
    IFID_UsesRt = 0; BranchTaken = 0; MemReq = 0; MemReady = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    clr();
    #2 Reset = 0;
    #3 Reset = 1;
    tick();
  endtask

  initial begin
    int exp_stall, exp_flush;
    vecs[0]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[1]  = '{1'b1, 5'd8,  5'd8,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
    vecs[2]  = '{1'b1, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[3]  = '{1'b1, 5'd9,  5'd1,  5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU};
    vecs[4]  = '{1'b1, 5'd9,  5'd1,  5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5]  = '{1'b0, 5'd8,  5'd8,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[6]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR};
    vecs[7]  = '{1'b1, 5'd8,  5'd8,  5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR};
    vecs[8]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM};
    vecs[9]  = '{1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NORM};
    vecs[10] = '{1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
    vecs[11] = '{1'b1, 5'd0,  5'd5,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM};

    #1;
    chk("reset_outs", outs(), 0);
    chk("reset_state", State, 0);
    chk("reset_stallcnt", StallCount, 0);
    #3 Reset = 1;
    tick();
    chk("run_idle_outs", outs(), NORM);

    exp_stall = 0; exp_flush = 0;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d_outs", i), outs(), vecs[i].exp);
      exp_stall += (vecs[i].exp[7] == 1'b0) ? 1 : 0;
      exp_flush += vecs[i].exp[3] ? 1 : 0;
      tick();
      chk($sformatf("vec%0d_state", i), State, 0);
    end
    clr(); #1;
    chk("table_stallcnt", StallCount, exp_stall);
    chk("table_flushcnt", FlushCount, exp_flush);

    do_reset();
    MemReq = 1; MemReady = 0; #1;
    chk("mw_c1_outs", outs(), FRZ);
    chk("mw_c1_state", State, 0);
    for (int c = 2; c <= 4; c++) begin
      tick();
      chk($sformatf("mw_c%0d_outs", c), outs(), FRZ);
      chk($sformatf("mw_c%0d_state", c), State, 1);
    end
    tick();
    MemReady = 1; #1;
    chk("mw_ready_outs", outs(), NORM);
    chk("mw_ready_state", State, 1);
    tick();
    clr(); #1;
    chk("mw_done_state", State, 0);
    chk("mw_stallcnt", StallCount, 4);

    do_reset();
    MemReq = 1; MemReady = 0; BranchTaken = 1;
    IDEX_MemRead = 1; IDEX_Rt = 8; IFID_Rs = 8; #1;
    chk("prio_all_outs", outs(), FRZ);
    tick();
    MemReady = 1; #1;
    chk("prio_br_lu_outs", outs(), BR);
    tick();
    clr(); #1;
    chk("prio_stallcnt", StallCount, 1);
    chk("prio_flushcnt", FlushCount, 1);
    chk("prio_state", State, 0);

    do_reset();
    MemReq = 1; MemReady = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("to_state_c%0d", c), State, c == 5 ? 2 : 1);
    end
    chk("to_err_outs", outs(), ERRF);
    MemReady = 1; #1;
    chk("to_err_ready_outs", outs(), ERRF);
    MemReq = 0;
    for (int c = 0; c < 20; c++) tick();
    chk("to_err_stay", State, 2);
    chk("to_stall_sat", StallCount, 15);
    chk("to_flushcnt", FlushCount, 0);

    do_reset();
    MemReq = 1; MemReady = 0;
    tick(); tick();
    chk("ar_pre_state", State, 1);
    #1 Reset = 0;
    #1;
    chk("ar_outs", outs(), 0);
    chk("ar_state", State, 0);
    chk("ar_stallcnt", StallCount, 0);
    Reset = 1; clr(); #1;
    chk("ar_rel_outs", outs(), NORM);
    tick();
    chk("ar_rel_state", State, 0);
    chk("ar_rel_stallcnt", StallCount, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
